// File: rtl/gusn_pkg.sv
// Shared definitions for the classifier datapath: class count, argmax index width,
// dense-layer FSM states and the ROM address width helper.
package gusn_pkg;

  localparam int unsigned NUM_CLASSES = 10;
  localparam int unsigned IDX_W       = 4;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDrain,
    StWrite,
    StOut
  } dense_state_t;

  // Each neuron occupies in_n weight words followed by one bias word.
  function automatic int unsigned rom_addr_w(input int unsigned in_n);
    return $clog2(NUM_CLASSES * (in_n + 1));
  endfunction

endpackage

// File: rtl/sat_rshift.sv
// Combinational arithmetic right shift (floor) followed by a signed clamp to WIDTH bits.
module sat_rshift #(
  parameter int unsigned ACC_W = 24,
  parameter int unsigned FRAC  = 6,
  parameter int unsigned WIDTH = 8
) (
  input  logic [ACC_W-1:0] i_acc,
  output logic [WIDTH-1:0] o_sat
);

  localparam logic signed [ACC_W-1:0] MaxV = {{(ACC_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MinV = {{(ACC_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  logic signed [ACC_W-1:0] w_shift;

  assign w_shift = $signed(i_acc) >>> FRAC;

  always_comb begin
    if (w_shift > MaxV) begin
      o_sat = MaxV[WIDTH-1:0];
    end else if (w_shift < MinV) begin
      o_sat = MinV[WIDTH-1:0];
    end else begin
      o_sat = w_shift[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/dense_out10.sv
// Time-multiplexed 10-neuron output layer: one signed MAC walks the weight/bias ROM,
// saturates each logit and hands the full vector to argmax with a one-cycle start pulse.
module dense_out10 import gusn_pkg::*; #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned IN_N   = 16,
  parameter int unsigned W_W    = 8,
  parameter int unsigned ACC_W  = 24,
  parameter int unsigned FRAC   = 6,
  localparam int unsigned ADDR_W = rom_addr_w(IN_N)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [IN_N*WIDTH-1:0]        in_vec,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [ADDR_W-1:0]            w_addr,
  input  logic [W_W-1:0]               w_rdata,
  output logic [NUM_CLASSES*WIDTH-1:0] out_vec,
  input  logic                         out_ready,
  output logic                         out_start
);

  localparam int unsigned KW     = $clog2(IN_N + 1);
  localparam int unsigned Stride = IN_N + 1;

  dense_state_t                   r_state, w_state_next;
  logic [IN_N*WIDTH-1:0]          r_in;
  logic [IDX_W-1:0]               r_n;
  logic [KW-1:0]                  r_k;
  logic [KW-1:0]                  r_pk;
  logic                           r_pvalid;
  logic [ACC_W-1:0]               r_acc;
  logic [NUM_CLASSES*WIDTH-1:0]   r_out;

  logic [WIDTH-1:0]               w_act;
  logic signed [WIDTH+W_W-1:0]    w_prod;
  logic [ACC_W-1:0]               w_term;
  logic [WIDTH-1:0]               w_logit;

  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_start    = 1'b0;
    w_addr       = '0;
    unique case (r_state)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) w_state_next = StFetch;
      end
      StFetch: begin
        w_addr = ADDR_W'(r_n * Stride + r_k);
        if (r_k == KW'(IN_N)) w_state_next = StDrain;
      end
      StDrain: w_state_next = StWrite;
      StWrite: begin
        w_state_next = (r_n == IDX_W'(NUM_CLASSES - 1)) ? StOut : StFetch;
      end
      StOut: begin
        if (out_ready) begin
          out_start    = 1'b1;
          w_state_next = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= StIdle;
    else       r_state <= w_state_next;
  end

  // Select the activation matching the word now returning from the ROM.
  always_comb begin
    w_act = '0;
    for (int unsigned i = 0; i < IN_N; i++) begin
      if (r_pk == KW'(i)) w_act = r_in[i*WIDTH +: WIDTH];
    end
  end

  assign w_prod = $signed(w_act) * $signed(w_rdata);

  always_comb begin
    if (r_pk == KW'(IN_N)) begin
      w_term = {{(ACC_W-W_W){w_rdata[W_W-1]}}, w_rdata} << FRAC;
    end else begin
      w_term = {{(ACC_W-WIDTH-W_W){w_prod[WIDTH+W_W-1]}}, w_prod};
    end
  end

  sat_rshift #(
    .ACC_W (ACC_W),
    .FRAC  (FRAC),
    .WIDTH (WIDTH)
  ) u_sat (
    .i_acc (r_acc),
    .o_sat (w_logit)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_in     <= '0;
      r_n      <= '0;
      r_k      <= '0;
      r_pk     <= '0;
      r_pvalid <= 1'b0;
      r_acc    <= '0;
      r_out    <= '0;
    end else begin
      r_pvalid <= (r_state == StFetch);
      r_pk     <= r_k;
      if (r_pvalid) r_acc <= r_acc + w_term;
      case (r_state)
        StIdle: begin
          if (in_valid) begin
            r_in  <= in_vec;
            r_acc <= '0;
            r_n   <= '0;
            r_k   <= '0;
          end
        end
        StFetch: begin
          if (r_k != KW'(IN_N)) r_k <= r_k + 1'b1;
        end
        StWrite: begin
          r_out[r_n*WIDTH +: WIDTH] <= w_logit;
          r_acc <= '0;
          r_k   <= '0;
          if (r_n != IDX_W'(NUM_CLASSES - 1)) r_n <= r_n + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign out_vec = r_out;

endmodule

// File: tb/tb_dense_out10.sv
// Randomized and directed bench for dense_out10 against a sum-of-products reference model.
module tb_dense_out10;
  import gusn_pkg::*;

  localparam int unsigned IN_N = 4;
  localparam int unsigned FRAC = 0;
  localparam int unsigned AW   = rom_addr_w(4);
  localparam int unsigned AW2  = rom_addr_w(1);
  localparam int          LAT  = 10 * (4 + 3);
  localparam int          LAT2 = 10 * (1 + 3);

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [31:0]   in_vec = '0;
  logic          in_valid = 1'b0, in_ready, out_ready = 1'b1, out_start;
  logic [AW-1:0] w_addr;
  logic [7:0]    w_rdata;
  logic [79:0]   out_vec;

  logic [7:0]     in_vec2 = '0;
  logic           in_valid2 = 1'b0, in_ready2, out_ready2 = 1'b1, out_start2;
  logic [AW2-1:0] w_addr2;
  logic [7:0]     w_rdata2;
  logic [79:0]    out_vec2;

  dense_out10 #(.WIDTH(8), .IN_N(4), .W_W(8), .ACC_W(24), .FRAC(0)) u_dut (
    .clk(clk), .reset(reset), .in_vec(in_vec), .in_valid(in_valid), .in_ready(in_ready),
    .w_addr(w_addr), .w_rdata(w_rdata), .out_vec(out_vec), .out_ready(out_ready),
    .out_start(out_start)
  );

  dense_out10 #(.WIDTH(8), .IN_N(1), .W_W(8), .ACC_W(24), .FRAC(6)) u_dut_f (
    .clk(clk), .reset(reset), .in_vec(in_vec2), .in_valid(in_valid2), .in_ready(in_ready2),
    .w_addr(w_addr2), .w_rdata(w_rdata2), .out_vec(out_vec2), .out_ready(out_ready2),
    .out_start(out_start2)
  );

  logic signed [7:0] rom [64];
  logic signed [7:0] rom2 [32];

  always @(posedge clk) begin
    w_rdata  <= rom[w_addr];
    w_rdata2 <= rom2[w_addr2];
  end

  int n_cmp = 0, n_err = 0, cyc = 0, n_start = 0;
  bit chk_en = 1'b0, rand_rdy = 1'b0;

  always @(posedge clk) cyc++;

  always @(posedge clk) if (rand_rdy) begin
    #1 out_ready = 1'($urandom_range(0, 1));
  end

  task automatic chk(input string name, input logic [79:0] got, input logic [79:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic int sat_floor(input int acc, input int frac);
    int d, q;
    d = 1 << frac;
    q = acc / d;
    if ((acc % d) != 0 && acc < 0) q = q - 1;
    if (q > 127) q = 127;
    if (q < -128) q = -128;
    return q;
  endfunction

  function automatic logic [79:0] model_vec(input logic [31:0] v);
    logic [79:0] r;
    int acc, a, w;
    r = '0;
    for (int n = 0; n < 10; n++) begin
      acc = 0;
      for (int k = 0; k < IN_N; k++) begin
        a = $signed(v[k*8 +: 8]);
        w = rom[n*(IN_N+1)+k];
        acc += a * w;
      end
      w = rom[n*(IN_N+1)+IN_N];
      acc += w * (1 << FRAC);
      r[n*8 +: 8] = 8'(sat_floor(acc, FRAC));
    end
    return r;
  endfunction

  // Model: idle / computing for LAT cycles / presenting until out_ready.
  int m_phase = 0, m_cnt = 0;
  logic [79:0] m_vec = '0, m_pend = '0;

  always @(posedge clk) begin
    if (reset) begin
      m_phase = 0;
      m_vec   = '0;
    end else begin
      case (m_phase)
        0: if (in_valid) begin
          m_pend  = model_vec(in_vec);
          m_cnt   = 0;
          m_phase = 1;
        end
        1: begin
          m_cnt++;
          if (m_cnt == LAT) begin
            m_phase = 2;
            m_vec   = m_pend;
          end
        end
        default: if (out_ready) m_phase = 0;
      endcase
    end
  end

  always @(negedge clk) if (chk_en) begin
    chk("in_ready", 80'(in_ready), 80'(m_phase == 0));
    chk("out_start", 80'(out_start), 80'(m_phase == 2 && out_ready));
    if (m_phase != 1) chk("out_vec", out_vec, m_vec);
    if (out_start) n_start++;
  end

  task automatic run_vec(input logic [31:0] v, input bit noise,
                         output logic [79:0] got, output int lat);
    int t0;
    bit seen;
    seen = 0; got = '0; lat = -1;
    @(posedge clk); #1 in_vec = v; in_valid = 1'b1;
    @(posedge clk); #1 t0 = cyc; in_valid = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      if (out_start) begin
        seen = 1; got = out_vec; lat = cyc - t0;
      end else begin
        @(posedge clk); #1;
        if (noise && (cyc - t0) < LAT - 10) begin
          in_valid = 1'($urandom_range(0, 1));
          in_vec   = $urandom;
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    in_valid = 1'b0;
    if (!seen) begin
      n_cmp++; n_err++;
      $display("FAIL run_vec timeout: out_start got none required one within 400 cycles");
    end
  endtask

  task automatic run_f(input logic [7:0] v, output logic [79:0] got, output int lat);
    int t0;
    bit seen;
    seen = 0; got = '0; lat = -1;
    @(posedge clk); #1 in_vec2 = v; in_valid2 = 1'b1;
    @(posedge clk); #1 t0 = cyc; in_valid2 = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (out_start2) begin
        seen = 1; got = out_vec2; lat = cyc - t0;
      end
    end
    if (!seen) begin
      n_cmp++; n_err++;
      $display("FAIL run_f timeout: out_start got none required one within 200 cycles");
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [79:0] got, e1, e2;
    int lat, s0, t0;
    logic [31:0] v;
    for (int i = 0; i < 64; i++) rom[i] = '0;
    for (int i = 0; i < 32; i++) rom2[i] = '0;
    repeat (2) @(posedge clk);
    #1 chk_en = 1'b1;
    @(posedge clk); #1 reset = 1'b0;

    @(negedge clk);
    chk("rst in_ready", 80'(in_ready), 80'd1);
    chk("rst out_start", 80'(out_start), 80'd0);
    chk("rst out_vec", out_vec, 80'd0);
    chk("rst w_addr", 80'(w_addr), 80'd0);
    chk("rst out_vec2", out_vec2, 80'd0);

    // Zero weights, bias n.
    for (int n = 0; n < 10; n++) begin
      for (int k = 0; k < 4; k++) rom[n*5+k] = 8'sd0;
      rom[n*5+4] = 8'(n);
      e1[n*8 +: 8] = 8'(n);
    end
    s0 = n_start;
    run_vec($urandom, 1'b0, got, lat);
    chk("bias vec", got, e1);
    chk("bias latency", 80'(lat), 80'(LAT));
    @(posedge clk); #1;
    @(negedge clk);
    chk("bias in_ready after", 80'(in_ready), 80'd1);
    repeat (5) @(negedge clk);
    chk("bias single pulse", 80'(n_start - s0), 80'd1);

    // w=n-4, in={1,2,3,4}, stalled downstream, busy in_valid pulse.
    for (int n = 0; n < 10; n++) begin
      for (int k = 0; k < 4; k++) rom[n*5+k] = 8'(n - 4);
      rom[n*5+4] = 8'sd0;
      e2[n*8 +: 8] = 8'(10 * (n - 4));
    end
    s0 = n_start;
    @(posedge clk); #1 out_ready = 1'b0; in_vec = 32'h04030201; in_valid = 1'b1;
    @(posedge clk); #1 t0 = cyc; in_valid = 1'b0;
    while (cyc - t0 < 30) begin @(posedge clk); #1; end
    in_valid = 1'b1; in_vec = $urandom;
    @(posedge clk); #1 in_valid = 1'b0;
    while (cyc - t0 < LAT) begin @(posedge clk); #1; end
    repeat (5) begin
      @(negedge clk);
      chk("stall in_ready", 80'(in_ready), 80'd0);
      chk("stall out_start", 80'(out_start), 80'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("stall release start", 80'(out_start), 80'd1);
    chk("weighted vec", out_vec, e2);
    @(posedge clk); #1;
    @(negedge clk);
    chk("stall idle", 80'(in_ready), 80'd1);
    chk("stall no 2nd start", 80'(out_start), 80'd0);
    chk("stall single pulse", 80'(n_start - s0), 80'd1);

    // Saturation.
    for (int i = 0; i < 50; i++) rom[i] = (i % 5 == 4) ? 8'sd0 : 8'sd127;
    run_vec(32'h7f7f7f7f, 1'b1, got, lat);
    chk("sat high", got, {10{8'h7f}});
    for (int i = 0; i < 50; i++) rom[i] = (i % 5 == 4) ? 8'sd0 : -8'sd128;
    run_vec(32'h7f7f7f7f, 1'b1, got, lat);
    chk("sat low", got, {10{8'h80}});

    // Random weights/activations, optionally random out_ready.
    for (int it = 0; it < 8; it++) begin
      for (int i = 0; i < 50; i++)
        rom[i] = (it % 2 == 0) ? 8'($urandom_range(0, 15) - 8) : 8'($urandom);
      v = $urandom;
      rand_rdy = 1'($urandom_range(0, 1));
      run_vec(v, 1'b1, got, lat);
      chk("rnd vec", got, model_vec(v));
      if (!rand_rdy) chk("rnd latency", 80'(lat), 80'(LAT));
      @(posedge clk); #2 rand_rdy = 1'b0; out_ready = 1'b1;
    end

    // Reset during FETCH of neuron 3.
    for (int n = 0; n < 10; n++) begin
      for (int k = 0; k < 4; k++) rom[n*5+k] = 8'sd0;
      rom[n*5+4] = 8'(n);
    end
    s0 = n_start;
    @(posedge clk); #1 in_vec = $urandom; in_valid = 1'b1;
    @(posedge clk); #1 t0 = cyc; in_valid = 1'b0;
    while (cyc - t0 < 23) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("abort in_ready", 80'(in_ready), 80'd1);
    chk("abort out_start", 80'(out_start), 80'd0);
    chk("abort out_vec", out_vec, 80'd0);
    repeat (80) @(negedge clk);
    chk("abort no start", 80'(n_start - s0), 80'd0);
    run_vec($urandom, 1'b0, got, lat);
    chk("post-abort vec", got, e1);
    chk("post-abort latency", 80'(lat), 80'(LAT));

    // IN_N=1, FRAC=6 instance: floor shift.
    for (int n = 0; n < 10; n++) begin
      rom2[2*n]   = 8'sd1;
      rom2[2*n+1] = 8'sd0;
    end
    run_f(8'hbf, got, lat);
    chk("frac -65", got, {10{8'hfe}});
    chk("frac latency", 80'(lat), 80'(LAT2));
    run_f(8'd63, got, lat);
    chk("frac 63", got, 80'd0);
    for (int n = 0; n < 10; n++) rom2[2*n] = 8'(n + 1);
    run_f(8'd100, got, lat);
    chk("frac ramp", got, {8'd15, 8'd14, 8'd12, 8'd10, 8'd9, 8'd7, 8'd6, 8'd4, 8'd3, 8'd1});

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
